mmcm_phase_sweep: RTL

MMCM_PHASE_SWEEP -- requirements
Module: mmcm_phase_sweep

---
 rtl/mmcm_phase_sweep_pkg.sv | 25 ++
 rtl/mmcm_phase_sweep_window_tracker.sv | 118 +++++++++++
 rtl/mmcm_phase_sweep.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mmcm_phase_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module : mmcm_phase_sweep_pkg
// Brief  : Sweep FSM state encoding and guard timing shared with phase-counter users.
// Rev    : 1.0
// ============================================================================
package mmcm_phase_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_GUARD   = 3'd2,
    ST_WAIT_PS = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_MEAS    = 3'd5,
    ST_NEXT    = 3'd6,
    ST_FINISH  = 3'd7
  } sweep_state_e;

  // ps_ready is ignored for this many cycles after a write so a stale ready is not trusted
  localparam int unsigned GUARD_CYCLES = 2;
  localparam int unsigned GUARD_CNT_W  = 2;

endpackage
`default_nettype wire

// File: rtl/mmcm_phase_sweep_window_tracker.sv
`default_nettype none
// ============================================================================
// Module : phase_window_tracker
// Brief  : Tracks the longest run of passing phase points and its center.
// Rev    : 1.0
// ============================================================================
module phase_window_tracker #(
  parameter int PHASE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   sample_i,
  input  logic                   pass_i,
  input  logic                   finalize_i,
  input  logic [PHASE_WIDTH-1:0] phase_i,
  input  logic [PHASE_WIDTH-1:0] step_i,
  output logic                   found_o,
  output logic [PHASE_WIDTH-1:0] win_first_o,
  output logic [PHASE_WIDTH-1:0] win_len_o,
  output logic [PHASE_WIDTH-1:0] win_center_o
);

  localparam int PW = PHASE_WIDTH;

  logic [PW-1:0] run_len_q, run_len_d, run_first_q, run_first_d;
  logic [PW-1:0] best_len_q, best_len_d, best_first_q, best_first_d;
  logic [PW-1:0] res_len_q, res_len_d, res_first_q, res_first_d;
  logic [PW-1:0] res_center_q, res_center_d;
  logic          res_found_q, res_found_d;

  logic [PW-1:0] ext_len, ext_first, fin_len, fin_first;

  // Center offset is a signed span evaluated at double width, halved arithmetically
  function automatic logic [PW-1:0] calc_center(input logic [PW-1:0] first,
                                                input logic [PW-1:0] len,
                                                input logic [PW-1:0] step);
    logic signed [2*PW-1:0] span;
    logic [PW-1:0]          len_m1;
    logic [PW-1:0]          result;
    len_m1 = len - PW'(1);
    span   = $signed({{PW{1'b0}}, len_m1}) * $signed({{PW{step[PW-1]}}, step});
    if (len == '0) result = first;
    else           result = first + span[PW:1];
    return result;
  endfunction

  assign ext_len   = run_len_q + PW'(1);
  assign ext_first = (run_len_q == '0) ? phase_i : run_first_q;
  assign fin_len   = (run_len_q > best_len_q) ? run_len_q   : best_len_q;
  assign fin_first = (run_len_q > best_len_q) ? run_first_q : best_first_q;

  always_comb begin
    run_len_d    = run_len_q;
    run_first_d  = run_first_q;
    best_len_d   = best_len_q;
    best_first_d = best_first_q;
    res_len_d    = res_len_q;
    res_first_d  = res_first_q;
    res_center_d = res_center_q;
    res_found_d  = res_found_q;

    if (clear_i) begin
      run_len_d    = '0;
      run_first_d  = '0;
      best_len_d   = '0;
      best_first_d = '0;
    end else if (sample_i) begin
      if (pass_i) begin
        run_len_d   = ext_len;
        run_first_d = ext_first;
        // strictly longer only, so the earliest of equal windows is kept
        if (ext_len > best_len_q) begin
          best_len_d   = ext_len;
          best_first_d = ext_first;
        end
      end else begin
        run_len_d = '0;
      end
    end

    if (finalize_i) begin
      res_found_d  = (fin_len != '0);
      res_len_d    = fin_len;
      res_first_d  = fin_first;
      res_center_d = calc_center(fin_first, fin_len, step_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_len_q    <= '0;
      run_first_q  <= '0;
      best_len_q   <= '0;
      best_first_q <= '0;
      res_len_q    <= '0;
      res_first_q  <= '0;
      res_center_q <= '0;
      res_found_q  <= 1'b0;
    end else begin
      run_len_q    <= run_len_d;
      run_first_q  <= run_first_d;
      best_len_q   <= best_len_d;
      best_first_q <= best_first_d;
      res_len_q    <= res_len_d;
      res_first_q  <= res_first_d;
      res_center_q <= res_center_d;
      res_found_q  <= res_found_d;
    end
  end

  assign found_o      = res_found_q;
  assign win_first_o  = res_first_q;
  assign win_len_o    = res_len_q;
  assign win_center_o = res_center_q;

endmodule
`default_nettype wire

// File: rtl/mmcm_phase_sweep.sv
`default_nettype none
// ============================================================================
// Module : mmcm_phase_sweep
// Brief  : Steps an MMCM phase counter through a range and finds the best pass window.
// Rev    : 1.0
// ============================================================================
module mmcm_phase_sweep
  import mmcm_phase_sweep_pkg::*;
#(
  parameter int PHASE_WIDTH  = 8,
  parameter int SETTLE_WIDTH = 8
) (
  input  logic                    psclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PHASE_WIDTH-1:0]  phase_start,
  input  logic [PHASE_WIDTH-1:0]  phase_step,
  input  logic [PHASE_WIDTH-1:0]  num_steps,
  input  logic [SETTLE_WIDTH-1:0] settle,
  output logic                    ps_we,
  output logic [PHASE_WIDTH-1:0]  ps_din,
  input  logic                    ps_ready,
  output logic                    meas_start,
  input  logic                    meas_done,
  input  logic                    meas_pass,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [PHASE_WIDTH-1:0]  win_first,
  output logic [PHASE_WIDTH-1:0]  win_len,
  output logic [PHASE_WIDTH-1:0]  win_center
);

  localparam int PW = PHASE_WIDTH;
  localparam int SW = SETTLE_WIDTH;

  sweep_state_e           state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d, step_q, step_d, nsteps_q, nsteps_d;
  logic [PW-1:0]          idx_q, idx_d, last_ps_q, last_ps_d;
  logic [SW-1:0]          settle_q, settle_d, scnt_q, scnt_d;
  logic [GUARD_CNT_W-1:0] guard_q, guard_d;
  logic                   issued_q, issued_d, pass_q, pass_d;
  logic                   trk_clear, trk_sample, trk_final;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    step_d     = step_q;
    nsteps_d   = nsteps_q;
    idx_d      = idx_q;
    last_ps_d  = last_ps_q;
    settle_d   = settle_q;
    scnt_d     = scnt_q;
    guard_d    = guard_q;
    issued_d   = issued_q;
    pass_d     = pass_q;
    ps_we      = 1'b0;
    meas_start = 1'b0;
    done       = 1'b0;
    trk_clear  = 1'b0;
    trk_sample = 1'b0;
    trk_final  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          trk_clear = 1'b1;
          step_d    = phase_step;
          nsteps_d  = num_steps;
          settle_d  = settle;
          phase_d   = phase_start;
          idx_d     = '0;
          state_d   = (num_steps != '0) ? ST_SET : ST_FINISH;
        end
      end
      ST_SET: begin
        if (ps_ready) begin
          ps_we     = 1'b1;
          last_ps_d = phase_q;
          guard_d   = '0;
          state_d   = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_CNT_W'(GUARD_CYCLES - 1)) state_d = ST_WAIT_PS;
        else                                           guard_d = guard_q + GUARD_CNT_W'(1);
      end
      ST_WAIT_PS: begin
        if (ps_ready) begin
          if (settle_q == '0) begin
            issued_d = 1'b0;
            state_d  = ST_MEAS;
          end else begin
            scnt_d   = settle_q;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        scnt_d = scnt_q - SW'(1);
        if (scnt_q == SW'(1)) begin
          issued_d = 1'b0;
          state_d  = ST_MEAS;
        end
      end
      ST_MEAS: begin
        // a completion coincident with the request belongs to an earlier measurement
        if (!issued_q) begin
          meas_start = 1'b1;
          issued_d   = 1'b1;
        end else if (meas_done) begin
          pass_d  = meas_pass;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        trk_sample = 1'b1;
        if (idx_q == nsteps_q - PW'(1)) begin
          state_d = ST_FINISH;
        end else begin
          phase_d = phase_q + step_q;
          idx_d   = idx_q + PW'(1);
          state_d = ST_SET;
        end
      end
      ST_FINISH: begin
        trk_final = 1'b1;
        done      = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      last_ps_d  = last_ps_q;
      ps_we      = 1'b0;
      meas_start = 1'b0;
      done       = 1'b0;
      trk_sample = 1'b0;
      trk_final  = 1'b0;
    end
  end

  always_ff @(posedge psclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      nsteps_q  <= '0;
      idx_q     <= '0;
      last_ps_q <= '0;
      settle_q  <= '0;
      scnt_q    <= '0;
      guard_q   <= '0;
      issued_q  <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      nsteps_q  <= nsteps_d;
      idx_q     <= idx_d;
      last_ps_q <= last_ps_d;
      settle_q  <= settle_d;
      scnt_q    <= scnt_d;
      guard_q   <= guard_d;
      issued_q  <= issued_d;
      pass_q    <= pass_d;
    end
  end

  assign ps_din = (state_q == ST_SET) ? phase_q : last_ps_q;
  assign busy   = (state_q != ST_IDLE);

  phase_window_tracker #(
    .PHASE_WIDTH (PW)
  ) u_tracker (
    .clk          (psclk),
    .rst          (rst),
    .clear_i      (trk_clear),
    .sample_i     (trk_sample),
    .pass_i       (pass_q),
    .finalize_i   (trk_final),
    .phase_i      (phase_q),
    .step_i       (step_q),
    .found_o      (found),
    .win_first_o  (win_first),
    .win_len_o    (win_len),
    .win_center_o (win_center)
  );

endmodule
`default_nettype wire
